fpga_b_i2c_slave: RTL and testbench
===================================

Name: fpga_b_i2c_slave

Overview:
Receive-side I2C target (FPGA B) for the FPGA A → FPGA B link. It samples the open-drain bus with the system clock and responds to write transactions addressed to ADDR. It assembles FRAME_BYTES received bytes, MSB-first, into one DATA_W-bit word and presents it with a one-cycle valid pulse. It is write-only and does no clock stretching.

Parameters:
ADDR, 7'd7, 7-bit target address this block responds to
FRAME_BYTES, 13, data bytes per frame
DATA_W, 104, frame width; must equal 8*FRAME_BYTES

Ports:
clk  input  1  system clock; must be at least 16x the SCL rate
rst  input  1  asynchronous, active-low reset
i2c_scl  input  1  bus clock; observed only, never driven
i2c_sda  inout  1  bus data; driven only to 0 or 'z'
data_out  output  DATA_W  last complete frame; byte 0 is in the MSBs
frame_valid  output  1  one-cycle pulse when data_out updates
frame_err  output  1  one-cycle pulse when a partial frame is aborted
busy  output  1  high from an addressed START until STOP

Behaviour:
- Reset: rst low → outputs clear immediately, no clock needed.
  - data_out=0, frame_valid=0, frame_err=0, busy=0.
  - SDA released ('z'), FSM=IDLE, byte count=0.
- Input conditioning:
  - SCL and SDA each pass through a 2-FF synchronizer plus one history register.
  - All edges are therefore detected 3 clk after the pin change.
- Bus conditions:
  - START: SDA falling while SCL high. STOP: SDA rising while SCL high.
  - Both are recognised in every state and override the current state.
- Bit sampling: data is sampled on detected SCL rising edges, shifted in MSB-first.
- FSM states: IDLE, ADDR, ADDR_ACK, RX, DATA_ACK, IGNORE.
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits on SCL rising edges.
    - 8th bit with addr==ADDR and rw=0 → ADDR_ACK.
    - Otherwise (wrong address, or rw=1) → IGNORE, SDA never driven.
  - ADDR_ACK:
    - On the SCL falling edge after the 8th bit, drive SDA=0.
    - On the next SCL falling edge, release SDA → RX.
  - RX: shift 8 bits; after the 8th rising edge → DATA_ACK.
  - DATA_ACK:
    - ACK (SDA=0) only if byte count < FRAME_BYTES; the byte is stored at index count, then count increments.
    - Otherwise NACK: SDA stays released and the byte is discarded.
    - SDA is released on the SCL falling edge that ends the ACK slot → RX.
  - IGNORE: wait for START or STOP.
- Frame completion:
  - When the byte at index FRAME_BYTES-1 is ACKed, data_out is loaded from the assembly buffer.
  - frame_valid pulses exactly 1 clk, on the cycle after the falling SCL edge that ends that ACK slot.
  - Count then equals FRAME_BYTES; further bytes are NACKed until STOP or START.
- Abort cases (STOP, or repeated START):
  - If 0 < count < FRAME_BYTES: pulse frame_err once; data_out is unchanged.
  - Count clears on any START or STOP.
  - Repeated START → ADDR. STOP → IDLE.
  - SDA is released in the same cycle the condition is detected.
- busy:
  - Rises on entry to ADDR_ACK.
  - Falls on STOP, or on a repeated START that is not re-addressed to ADDR.
- Simultaneous events:
  - STOP/START take priority over SCL-edge processing in the same cycle.
  - frame_valid and frame_err never assert together.
- SDA is never driven while SCL is high, except to hold an ACK already driven low.

Decomposition:
- Shared package i2c_link_pkg:
  - Constants: I2C_LINK_ADDR = 7'd7, I2C_FRAME_BYTES = 13, I2C_FRAME_W = 104.
  - State enum for this FSM.
  - The transmitter wrapper imports the same constants.
- Sub-module i2c_bus_sync:
  - 2-FF synchronizers and edge history.
  - Outputs: scl_rise, scl_fall, start_det, stop_det, sda_s.
  - Reusable by any future I2C target.

Test Plan:
1. Write to 0x07 (0x0E), bytes 0x01..0x0D, STOP → 14 ACKs seen. data_out = 104'h0102030405060708090A0B0C0D, frame_valid one pulse, frame_err=0.
2. Address byte 0x10 (addr 0x08) then 3 data bytes → SDA never low, busy=0, no pulses.
3. 0x0E, 5 bytes, STOP → frame_err one pulse, data_out keeps its prior value, busy falls at STOP.
4. 0x0E, 14 bytes → 13th byte ACKed and frame_valid pulses, 14th byte NACKed, data_out equals the first 13 bytes.
5. Read request 0x0F → address NACK, FSM enters IGNORE, SDA stays 'z' through 9 more SCL clocks.
6. rst low while SDA is held low in the byte-6 ACK slot → SDA 'z' immediately with no clk edge; all outputs 0. After release, a full frame as in test 1 succeeds.

Source files
------------

// File: rtl/i2c_link_pkg.sv
// Constants and FSM state type shared by both ends of the FPGA A -> FPGA B I2C link.
package i2c_link_pkg;

    localparam logic [6:0] I2C_LINK_ADDR   = 7'd7;
    localparam int         I2C_FRAME_BYTES = 13;
    localparam int         I2C_FRAME_W     = 104;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_DATA_ACK,
        ST_IGNORE
    } i2c_rx_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and derives edge and START/STOP strobes.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    // [0] metastable stage, [1] synchronized, [2] history; reset to idle-high bus
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    assign sda_s     = sda_q[1];
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/fpga_b_i2c_slave.sv
// Write-only I2C target: collects FRAME_BYTES bytes after ADDR+W into one word.
module fpga_b_i2c_slave
    import i2c_link_pkg::*;
#(
    parameter logic [6:0] ADDR        = I2C_LINK_ADDR,
    parameter int         FRAME_BYTES = I2C_FRAME_BYTES,
    parameter int         DATA_W      = I2C_FRAME_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2c_scl,
    inout  wire               i2c_sda,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int                CNT_W = $clog2(FRAME_BYTES + 1);
    localparam logic [CNT_W-1:0]  FB    = CNT_W'(FRAME_BYTES);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (i2c_scl),
        .sda       (i2c_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_rx_state_e     state_q, state_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              fv_q, fv_d, fe_q, fe_d, busy_q, busy_d;
    logic              oe_q, oe_d, slot_q, slot_d, ack_q, ack_d;
    logic [7:0]        rx_byte;

    assign rx_byte = {shift_q[6:0], sda_s};

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        dout_d  = dout_q;
        fv_d    = 1'b0;
        fe_d    = 1'b0;
        busy_d  = busy_q;
        oe_d    = oe_q;
        slot_d  = slot_q;
        ack_d   = ack_q;
        if (start_det || stop_det) begin
            fe_d   = (cnt_q != '0) && (cnt_q < FB);
            cnt_d  = '0;
            oe_d   = 1'b0;
            slot_d = 1'b0;
            bit_d  = '0;
            if (stop_det) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end else begin
                state_d = ST_ADDR;
            end
        end else begin
            unique case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d = rx_byte;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (rx_byte == {ADDR, 1'b0}) begin
                            state_d = ST_ADDR_ACK;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                // oe_q doubles as the phase flag: first fall drives, second releases
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        oe_d    = 1'b0;
                        state_d = ST_RX;
                    end
                end
                ST_RX: if (scl_rise) begin
                    shift_d = rx_byte;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_DATA_ACK;
                        slot_d  = 1'b0;
                    end
                end
                // Bytes shift in from the LSB end, so byte 0 lands in the MSBs after a full frame
                ST_DATA_ACK: if (scl_fall) begin
                    if (!slot_q) begin
                        slot_d = 1'b1;
                        ack_d  = cnt_q < FB;
                        if (cnt_q < FB) begin
                            oe_d  = 1'b1;
                            buf_d = {buf_q[DATA_W-9:0], shift_q};
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        slot_d  = 1'b0;
                        oe_d    = 1'b0;
                        state_d = ST_RX;
                        if (ack_q && cnt_q == FB) begin
                            dout_d = buf_q;
                            fv_d   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            dout_q  <= '0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
            slot_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            dout_q  <= dout_d;
            fv_q    <= fv_d;
            fe_q    <= fe_d;
            busy_q  <= busy_d;
            oe_q    <= oe_d;
            slot_q  <= slot_d;
            ack_q   <= ack_d;
        end
    end

    assign i2c_sda     = oe_q ? 1'b0 : 1'bz;
    assign data_out    = dout_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fpga_b_i2c_slave.sv
// Bus-level master driving the receiver, with a pulse scoreboard fed by a transaction model.
module tb_fpga_b_i2c_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    wire  sda_bus;

    assign sda_bus = m_sda ? 1'bz : 1'b0;
    pullup (sda_bus);

    logic [103:0] data_out;
    logic         frame_valid, frame_err, busy;

    fpga_b_i2c_slave dut (
        .clk         (clk),
        .rst         (rst),
        .i2c_scl     (m_scl),
        .i2c_sda     (sda_bus),
        .data_out    (data_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           err;
        logic [103:0] data;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad = 0;
    logic [103:0] model_frame = '0;
    bit           pend_err = 1'b0;
    logic [7:0]   txb [0:15];

    task automatic chk(input string nm, input logic [103:0] act, input logic [103:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input bit err, input logic [103:0] d);
        exp_t e;
        e.err  = err;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // one SCL period: drive b during low, sample the bus mid-high
    task automatic bit_out(input bit b, input bit exp_b, input string nm);
        m_sda = b;
        wclk(4);
        m_scl = 1'b1;
        wclk(4);
        chk(nm, 104'(sda_bus), 104'(exp_b));
        wclk(4);
        m_scl = 1'b0;
        wclk(4);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit ack, input string nm);
        for (int i = 7; i >= 0; i--) bit_out(v[i], v[i], {nm, " bit"});
        bit_out(1'b1, ~ack, {nm, " ack"});
    endtask

    task automatic start_c();
        m_sda = 1'b0; wclk(8);
        m_scl = 1'b0; wclk(4);
    endtask

    task automatic rep_c();
        m_sda = 1'b1; wclk(4);
        m_scl = 1'b1; wclk(4);
        m_sda = 1'b0; wclk(4);
        m_scl = 1'b0; wclk(4);
    endtask

    task automatic stop_c();
        m_sda = 1'b0; wclk(4);
        m_scl = 1'b1; wclk(4);
        m_sda = 1'b1; wclk(8);
    endtask

    // Reference: target ACKs address 0x0E, ACKs the first 13 data bytes, then NACKs;
    // a transaction cut short after 1..12 bytes reports an abort.
    task automatic send_txn(input bit rep, input logic [7:0] abyte, input int n, input bit stop_end);
        bit           addressed;
        bit           ack;
        logic [103:0] f;
        addressed = (abyte == 8'h0E);
        if (rep) begin
            if (pend_err) push_exp(1'b1, model_frame);
            rep_c();
        end else begin
            start_c();
        end
        pend_err = 1'b0;
        send_byte(abyte, addressed, "addr");
        chk("busy after address", 104'(busy), 104'(addressed));
        f = '0;
        for (int i = 0; i < n; i++) begin
            ack = addressed && (i < 13);
            if (ack) f[103 - 8*i -: 8] = txb[i];
            if (ack && i == 12) begin
                model_frame = f;
                push_exp(1'b0, f);
            end
            send_byte(txb[i], ack, "data");
        end
        if (addressed && n > 0 && n < 13) begin
            if (stop_end) push_exp(1'b1, model_frame);
            else pend_err = 1'b1;
        end
        if (stop_end) begin
            stop_c();
            chk("busy after stop", 104'(busy), 104'(0));
        end
    endtask

    // monitor: every pulse must match the next expected event
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && (frame_valid || frame_err)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected pulse: fv=%0b fe=%0b data=%0h, none expected", frame_valid, frame_err, data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_err", 104'(frame_err), 104'(e.err));
                    chk("frame_valid", 104'(frame_valid), 104'(!e.err));
                    chk("data_out", data_out, e.data);
                end
            end
        end
    end

    initial begin
        logic [7:0] ab;
        int         n;
        bit         se;
        bit         last_stop;

        #2 rst = 1'b0;
        wclk(3);
        chk("reset data_out", data_out, '0);
        chk("reset busy", 104'(busy), 104'(0));
        chk("reset frame_valid", 104'(frame_valid), 104'(0));
        chk("reset frame_err", 104'(frame_err), 104'(0));
        chk("reset sda released", 104'(sda_bus), 104'(1));
        rst = 1'b1;
        wclk(5);

        // 1: full frame
        for (int i = 0; i < 13; i++) txb[i] = 8'(i + 1);
        send_txn(1'b0, 8'h0E, 13, 1'b1);
        chk("test1 data_out", data_out, 104'h0102030405060708090A0B0C0D);

        // 2: wrong address
        send_txn(1'b0, 8'h10, 3, 1'b1);

        // 3: short frame aborted by STOP
        for (int i = 0; i < 5; i++) txb[i] = 8'hA0 + 8'(i);
        send_txn(1'b0, 8'h0E, 5, 1'b1);

        // 4: overlong frame, 14th byte NACKed
        for (int i = 0; i < 14; i++) txb[i] = 8'(8'h31 * (i + 3));
        send_txn(1'b0, 8'h0E, 14, 1'b1);

        // 5: read request
        txb[0] = 8'hFF;
        send_txn(1'b0, 8'h0F, 1, 1'b1);

        // 6: reset while holding the byte-6 ACK
        start_c();
        send_byte(8'h0E, 1'b1, "addr");
        for (int i = 0; i < 5; i++) send_byte(8'h5A, 1'b1, "data");
        for (int i = 7; i >= 0; i--) bit_out(1'b1, 1'b1, "data bit");
        m_sda = 1'b1; wclk(4);
        m_scl = 1'b1; wclk(4);
        chk("ack held before reset", 104'(sda_bus), 104'(0));
        #2 rst = 1'b0;
        #1;
        chk("async reset sda", 104'(sda_bus), 104'(1));
        chk("async reset data_out", data_out, '0);
        chk("async reset busy", 104'(busy), 104'(0));
        chk("async reset pulses", 104'({frame_valid, frame_err}), 104'(0));
        chk("no pending events at reset", 104'(exp_q.size()), 104'(0));
        model_frame = '0;
        pend_err    = 1'b0;
        wclk(4);
        rst = 1'b1;
        wclk(8);
        for (int i = 0; i < 13; i++) txb[i] = 8'(i + 1);
        send_txn(1'b0, 8'h0E, 13, 1'b1);

        // random transactions, some chained by repeated START
        last_stop = 1'b1;
        for (int t = 0; t < 14; t++) begin
            case ($urandom_range(0, 4))
                0:       ab = 8'($urandom);
                1:       ab = 8'h0F;
                default: ab = 8'h0E;
            endcase
            n  = int'($urandom_range(0, 15));
            se = (t == 13) || ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 16; i++) txb[i] = 8'($urandom);
            send_txn(!last_stop, ab, n, se);
            last_stop = se;
        end

        wclk(20);
        chk("scoreboard drained", 104'(exp_q.size()), 104'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
